// File: rtl/fp_product_normalizer.sv
// Post-multiply normalize / round-to-nearest-even stage for the single-precision multiply path.
// Two registered stages: stage 1 normalizes the raw 2.46 product, stage 2 rounds and packs.
module fp_product_normalizer #(
   parameter int BIAS  = 127,
   parameter int EXP_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] p,
   input  logic [7:0]  exp_a,
   input  logic [7:0]  exp_b,
   input  logic        sign,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        ovf,
   output logic        unf
);

   localparam logic signed [EXP_W-1:0] BIAS_W   = EXP_W'(BIAS);
   localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
   localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

   // Handshake: an item moves across a boundary only on a rising edge where valid & ready
   // are both high; a producer holds valid and data stable until that happens, and a
   // stage whose downstream is stalled keeps its contents unchanged.
   logic en1, en2;
   logic v1, v2;

   // stage 1 registers
   logic signed [EXP_W-1:0] e1;
   logic                    sign1, zero1, guard1, sticky1;
   logic [22:0]             frac1;

   // stage 1 next values
   logic signed [EXP_W-1:0] exp_sum;
   logic [22:0]             frac_d;
   logic                    guard_d, sticky_d;

   // stage 2 next values
   logic                    round_up, carry;
   logic [23:0]             frac_sum;
   logic signed [EXP_W-1:0] exp2;
   logic [31:0]             result_d;
   logic                    ovf_d, unf_d;

   assign en2       = !v2 || out_ready;
   assign en1       = !v1 || en2;
   assign in_ready  = en1;
   assign out_valid = v2;

   // An MSB-set product is in [2,4): take one extra bit off the bottom and bump the exponent.
   assign exp_sum = $signed({{(EXP_W-8){1'b0}}, exp_a})
                  + $signed({{(EXP_W-8){1'b0}}, exp_b})
                  - BIAS_W
                  + $signed({{(EXP_W-1){1'b0}}, p[47]});

   always_comb begin
      frac_d   = p[45:23];
      guard_d  = p[22];
      sticky_d = |p[21:0];
      if (p[47]) begin
         frac_d   = p[46:24];
         guard_d  = p[23];
         sticky_d = |p[22:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         e1      <= '0;
         sign1   <= 1'b0;
         zero1   <= 1'b0;
         frac1   <= '0;
         guard1  <= 1'b0;
         sticky1 <= 1'b0;
      end else if (en1) begin
         v1 <= in_valid;
         if (in_valid) begin
            e1      <= exp_sum;
            sign1   <= sign;
            zero1   <= (p == 48'd0);
            frac1   <= frac_d;
            guard1  <= guard_d;
            sticky1 <= sticky_d;
         end
      end
   end

   // {1,frac}+r overflows 24 bits exactly when frac+r overflows 23 bits, so the
   // hidden bit never needs to be carried through the adder.
   assign round_up = guard1 && (sticky1 || frac1[0]);
   assign frac_sum = {1'b0, frac1} + {23'd0, round_up};
   assign carry    = frac_sum[23];
   assign exp2     = e1 + $signed({{(EXP_W-1){1'b0}}, carry});

   always_comb begin
      result_d = {sign1, exp2[7:0], frac_sum[22:0]};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (zero1) begin
         result_d = {sign1, 31'd0};
      end else if (exp2 >= EXP_MAX) begin
         result_d = {sign1, 8'hFF, 23'd0};
         ovf_d    = 1'b1;
      end else if (exp2 <= EXP_ZERO) begin
         result_d = {sign1, 31'd0};
         unf_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2     <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else if (en2) begin
         v2 <= v1;
         if (v1) begin
            result <= result_d;
            ovf    <= ovf_d;
            unf    <= unf_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_product_normalizer.sv
// Bench for fp_product_normalizer: directed vectors, latency, backpressure, random
// traffic against an arithmetic rounding model, and reset with items in flight.
module tb_fp_product_normalizer;

   typedef struct packed {
      logic [47:0] p;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic        sign;
   } item_t;

   logic        clk, rst, in_valid, in_ready, sign, out_valid, out_ready, ovf, unf;
   logic [47:0] p;
   logic [7:0]  exp_a, exp_b;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];

   fp_product_normalizer #(.BIAS(127), .EXP_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .p(p), .exp_a(exp_a), .exp_b(exp_b), .sign(sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .unf(unf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value = P / 2^46 in [1,4); keep 24 significant bits, round the
   // discarded remainder against exactly one half ulp, ties to even.
   function automatic logic [33:0] model(input item_t it);
      logic [63:0] pw, m, rem, half;
      int sh, e;
      pw = 64'(it.p);
      if (pw == 64'd0) return {2'b00, it.sign, 31'd0};
      sh   = (pw >= (64'd1 << 47)) ? 24 : 23;
      e    = int'(it.ea) + int'(it.eb) - 127 + (sh - 23);
      m    = pw >> sh;
      rem  = pw & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {2'b10, it.sign, 8'hFF, 23'd0};
      if (e <= 0)   return {2'b01, it.sign, 31'd0};
      return {2'b00, it.sign, e[7:0], m[22:0]};
   endfunction

   function automatic item_t rand_item();
      item_t it;
      logic [23:0] a, b;
      a = {1'b1, 23'($urandom)};
      b = ($urandom_range(0, 3) == 0) ? 24'hC00000 : {1'b1, 23'($urandom)};
      it.p    = ($urandom_range(0, 15) == 0) ? 48'd0 : 48'(a) * 48'(b);
      it.ea   = 8'($urandom_range(1, 254));
      it.eb   = 8'($urandom_range(1, 254));
      it.sign = 1'($urandom);
      return it;
   endfunction

   // driver: one cycle; inputs change at negedge, outputs observed 1 time unit later
   task automatic tick(input logic iv, input item_t it, input logic ordy,
                       output logic acc, output logic got, output logic [33:0] obs);
      @(negedge clk);
      in_valid  = iv;
      p         = it.p;
      exp_a     = it.ea;
      exp_b     = it.eb;
      sign      = it.sign;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      obs = {ovf, unf, result};
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      p = '0; exp_a = '0; exp_b = '0; sign = 1'b0;
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({out_valid, ovf, unf, result} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {out_valid, ovf, unf, result});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      item_t       it[8];
      logic [33:0] want[8];
      logic        acc, got;
      logic [33:0] obs, e;
      int          sent = 0, budget = 40;
      it[0] = '{48'h400000000000, 8'h7F, 8'h7F, 1'b0}; want[0] = {2'b00, 32'h3F800000};
      it[1] = '{48'h900000000000, 8'h7F, 8'h7F, 1'b0}; want[1] = {2'b00, 32'h40100000};
      it[2] = '{48'h400000C00000, 8'h7F, 8'h7F, 1'b0}; want[2] = {2'b00, 32'h3F800002};
      it[3] = '{48'h400000400000, 8'h7F, 8'h7F, 1'b0}; want[3] = {2'b00, 32'h3F800000};
      it[4] = '{48'h7FFFFFC00000, 8'h7F, 8'h7F, 1'b0}; want[4] = {2'b00, 32'h40000000};
      it[5] = '{48'h400000000000, 8'hFE, 8'hFE, 1'b1}; want[5] = {2'b10, 32'hFF800000};
      it[6] = '{48'h400000000000, 8'h20, 8'h20, 1'b0}; want[6] = {2'b01, 32'h00000000};
      it[7] = '{48'h000000000000, 8'h7F, 8'h7F, 1'b1}; want[7] = {2'b00, 32'h80000000};
      while ((sent < 8 || exp_q.size() != 0) && budget > 0) begin
         tick(sent < 8, (sent < 8) ? it[sent] : '0, 1'b1, acc, got, obs);
         budget--;
         if (sent < 8) begin
            checks++;
            if (!acc) begin
               errors++;
               $display("FAIL directed_in_ready: got %b expected 1 (item %0d)", in_ready, sent);
            end
         end
         if (acc) begin
            exp_q.push_back(want[sent]);
            sent++;
         end
         if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL directed_extra: unexpected output %h", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL directed_result: got %h expected %h", obs, e);
               end
            end
         end
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL directed_timeout: %0d results missing, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_latency();
      item_t       it;
      logic        acc, got;
      logic [33:0] obs;
      int          n = 0;
      it = '{48'h900000000000, 8'h80, 8'h7F, 1'b1};
      tick(1'b1, it, 1'b1, acc, got, obs);
      got = 1'b0;
      while (!got && n < 10) begin
         tick(1'b0, it, 1'b1, acc, got, obs);
         n++;
      end
      checks++;
      if (n !== 2 || obs !== model(it)) begin
         errors++;
         $display("FAIL latency: got %0d cycles result %h expected 2 cycles result %h", n, obs, model(it));
      end
   endtask

   task automatic test_backpressure();
      item_t       it[3];
      logic        acc, got;
      logic [33:0] obs, held, e;
      int          sent = 0, outs = 0, last_out = -1, t = 0;
      for (int i = 0; i < 3; i++) it[i] = rand_item();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, it[sent], 1'b0, acc, got, obs);
         if (acc) begin
            exp_q.push_back(model(it[sent]));
            sent++;
         end
         if (i == 2) held = obs;
         if (i > 2) begin
            checks++;
            if (out_valid !== 1'b1 || obs !== held) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h expected 1/%h", out_valid, obs, held);
            end
         end
      end
      checks++;
      if (sent !== 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_accepts: got %0d accepts in_ready=%b expected 2/0", sent, in_ready);
      end
      while (outs < 3 && t < 20) begin
         tick(sent < 3, it[(sent < 3) ? sent : 2], 1'b1, acc, got, obs);
         if (acc) begin
            exp_q.push_back(model(it[sent]));
            sent++;
         end
         if (got) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3FFFFFFFF;
            if (obs !== e || (last_out >= 0 && t != last_out + 1)) begin
               errors++;
               $display("FAIL drain_order: got %h at cycle %0d expected %h at cycle %0d", obs, t, e, last_out + 1);
            end
            last_out = t;
            outs++;
         end
         t++;
      end
      checks++;
      if (outs !== 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_count: got %0d outputs expected 3", outs);
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      item_t       cur;
      logic        acc, got, iv, ordy;
      logic [33:0] obs, e;
      int          sent = 0, budget = 3000;
      cur = rand_item();
      while ((sent < 400 || exp_q.size() != 0) && budget > 0) begin
         iv   = (sent < 400) && ($urandom_range(0, 3) != 0);
         ordy = (sent >= 400) || ($urandom_range(0, 3) != 0);
         tick(iv, cur, ordy, acc, got, obs);
         budget--;
         if (acc) begin
            exp_q.push_back(model(cur));
            sent++;
            cur = rand_item();
         end
         if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL random_extra: unexpected output %h", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL random_result: got %h expected %h", obs, e);
               end
            end
         end
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL random_timeout: %0d results missing, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_inflight();
      logic        acc, got;
      logic [33:0] obs;
      for (int i = 0; i < 2; i++) tick(1'b1, rand_item(), 1'b0, acc, got, obs);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, ovf, unf, result} !== 35'd0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", {out_valid, ovf, unf, result});
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, '0, 1'b1, acc, got, obs);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: out_valid=%b expected 0", out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency();
      test_backpressure();
      test_back_to_back();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_product_normalizer.md
Name: fp_product_normalizer

Overview:
- Pipelined post-multiply stage for the single-precision multiply path in the DFT datapath. It sits directly downstream of the 24-bit mantissa multiplier.
- Consumes the raw 48-bit significand product, the two biased exponents and the result sign. Normalizes, rounds to nearest-even, applies overflow/underflow, and emits a packed IEEE-754 single result.
- Two register stages with a valid/ready handshake, so the combinational multiplier output is registered before rounding.

Parameters:
- BIAS, 127, exponent bias subtracted from EXP_A+EXP_B.
- EXP_W, 10, internal signed exponent width; must cover -BIAS..(2*254-BIAS+2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  P/EXP_A/EXP_B/SIGN are valid.
- IN_READY  output  1  stage can accept; a transfer occurs when IN_VALID & IN_READY at a rising edge.
- P  input  48  unsigned product of two 24-bit significands (hidden bit included), format 2.46.
- EXP_A  input  8  biased exponent, operand A.
- EXP_B  input  8  biased exponent, operand B.
- SIGN  input  1  result sign (A sign XOR B sign, computed upstream).
- OUT_VALID  output  1  RESULT/OVF/UNF are valid.
- OUT_READY  input  1  consumer accepts; a transfer occurs when OUT_VALID & OUT_READY.
- RESULT  output  32  {sign, 8-bit exponent, 23-bit fraction}.
- OVF  output  1  result saturated to infinity.
- UNF  output  1  result flushed to zero by exponent underflow.

Behaviour:
- Reset: asynchronous, active-high. Both stage valid bits clear. OUT_VALID=0, RESULT=0, OVF=0, UNF=0. IN_READY=1 once RST deasserts.
- Reset during operation discards all in-flight items; nothing is emitted for them.
- Pipeline enables:
  - en2 = !v2 | OUT_READY
  - en1 = !v1 | en2
  - IN_READY = en1 (combinational, no dependence on IN_VALID).
- Latency: exactly 2 cycles from input transfer to OUT_VALID when unstalled. Throughput is 1 per cycle.
- Stall rule: a stalled stage holds its data unchanged. No item is dropped or duplicated, and order is preserved.
- Stage 1 (on en1): register v1=IN_VALID, and when valid also register:
  - E1 = EXP_A + EXP_B - BIAS, sign-extended to EXP_W.
  - norm = P[47].
  - SIGN.
  - zero = (P == 0).
  - Significand fields:
    - If P[47]=1: frac = P[46:24], guard = P[23], sticky = |P[22:0], E1 += 1.
    - Else: frac = P[45:23], guard = P[22], sticky = |P[21:0].
- Stage 2 (on en2): v2 = v1, and when v1 is set:
  - Round up iff guard & (sticky | frac[0]).
  - Compute the 24-bit sum {1,frac} + roundup.
  - On carry-out: fraction = 0 and E2 = E1 + 1. Otherwise E2 = E1.
  - Priority:
    1. zero → RESULT = {SIGN, 31'b0}, OVF = 0, UNF = 0.
    2. E2 >= 255 → RESULT = {SIGN, 8'hFF, 23'b0}, OVF = 1.
    3. E2 <= 0 → RESULT = {SIGN, 31'b0}, UNF = 1 (no denormals).
    4. Otherwise RESULT = {SIGN, E2[7:0], fraction}.
- OVF and UNF are registered alongside RESULT and are meaningful only while OUT_VALID=1.
- Inf/NaN operands are not handled here; the upstream stage bypasses them.
- Simultaneous OUT_READY and IN_VALID with a full pipe: both stages advance in the same cycle and IN_READY stays 1.

Test Plan:
- 1.0×1.0: EXP_A=EXP_B=0x7F, P=0x400000000000, SIGN=0 → RESULT 0x3F800000 two cycles later, OVF=UNF=0.
- 1.5×1.5: EXP 0x7F/0x7F, P=0x900000000000 → 0x40100000 (normalize shift, exponent +1).
- Rounding (EXP 0x7F/0x7F):
  - Tie with odd lsb, P=0x400000C00000 → 0x3F800002.
  - Tie with even lsb, P=0x400000400000 → 0x3F800000.
  - Carry-out, P=0x7FFFFFC00000 → 0x40000000.
- Exponent limits:
  - EXP 0xFE/0xFE, P=0x400000000000, SIGN=1 → 0xFF800000, OVF=1.
  - EXP 0x20/0x20 → 0x00000000, UNF=1.
  - P=0, SIGN=1 → 0x80000000, no flags.
- Backpressure: OUT_READY=0 while 3 back-to-back inputs are offered → IN_READY falls after 2 accepts. Raise OUT_READY → 3 results out in order with no gaps or duplicates.
- Reset: assert RST with both stages valid → OUT_VALID=0 and RESULT=0 immediately (asynchronous), no stale output after release.
